text_line_streamer: RTL and testbench

- Parametrised successor to the fixed in-game text ROM.
- Streams one on-screen text line, a fixed label followed by a decimal rendering of a live binary value (e.g. "score:  42"), as 7-bit ASCII codes to the font renderer.
- Characters leave over a valid/ready handshake.
- Sits between game-state registers and the text drawing pipeline.

---
 rtl/text_line_streamer.sv | 208 ++++++++++++++++++++
 tb/tb_text_line_streamer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_line_streamer.sv
// Streams one text line (fixed label + decimal rendering of a binary value)
// as ASCII characters over a valid/ready handshake to the font renderer.
module text_line_streamer #(
    parameter int NUM_LINES = 2,
    parameter int LABEL_LEN = 6,
    parameter int VALUE_W   = 10,
    parameter int DIGITS    = 4,
    parameter int CHAR_W    = 7,
    parameter int ZERO_PAD  = 0,
    localparam int SEL_W    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1,
    localparam int COL_W    = (LABEL_LEN + DIGITS > 1) ? $clog2(LABEL_LEN + DIGITS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [SEL_W-1:0]  line_sel,
    input  logic [VALUE_W-1:0] value,
    output logic              busy,
    output logic              char_valid,
    input  logic              char_ready,
    output logic [CHAR_W-1:0] char_data,
    output logic [COL_W-1:0]  char_col,
    output logic              done
);

    // state       | meaning
    // IDLE        | waiting for start; line_sel/value latched on start
    // CONVERT     | double-dabble, one shift per cycle, VALUE_W cycles
    // EMIT_LABEL  | presenting label characters, columns 0..LABEL_LEN-1
    // EMIT_DIGITS | presenting decimal digits, most significant first
    // DONE        | one-cycle done pulse, then back to IDLE
    typedef enum logic [2:0] {
        IDLE,
        CONVERT,
        EMIT_LABEL,
        EMIT_DIGITS,
        DONE
    } state_t;

    localparam int BCD_W = 4 * (DIGITS + 1);
    localparam int CNT_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
    localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [COL_W-1:0]  LAST_LABEL_COL = COL_W'(LABEL_LEN - 1);
    localparam logic [COL_W-1:0]  LAST_COL       = COL_W'(LABEL_LEN + DIGITS - 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD       = CNT_W'(VALUE_W - 1);
    localparam logic [CHAR_W-1:0] ASCII_ZERO     = CHAR_W'(8'h30);
    localparam logic [CHAR_W-1:0] ASCII_SPACE    = CHAR_W'(8'h20);

    localparam logic [47:0] LINE0 = 48'h73_63_6f_72_65_3a;
    localparam logic [47:0] LINE1 = 48'h74_65_61_6d_3a_00;

    state_t              state;
    logic [SEL_W-1:0]    sel_q;
    logic [VALUE_W-1:0]  bin_q;
    logic [BCD_W-1:0]    bcd_q;
    logic                ovf_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DIG_W-1:0]    dig_q;

    logic [BCD_W-1:0]    bcd_adj;
    logic [BCD_W-1:0]    bcd_next;
    logic                shift_out;
    logic                sat;
    logic                seen;
    logic [3:0]          nib;
    logic [CHAR_W-1:0]   dchar [DIGITS];

    // Label ROM: rows beyond the defined lines, and columns beyond the stored
    // six characters, read as 00.
    function automatic logic [CHAR_W-1:0] label_char(input logic [SEL_W-1:0] ln,
                                                     input logic [COL_W-1:0] c);
        logic [47:0] row;
        logic [7:0]  ch;
        row = 48'h0;
        ch  = 8'h00;
        if (int'(ln) < NUM_LINES) begin
            if (int'(ln) == 0) begin
                row = LINE0;
            end else if (int'(ln) == 1) begin
                row = LINE1;
            end
        end
        if (int'(c) < LABEL_LEN && int'(c) < 6) begin
            ch = 8'(row >> (8 * (5 - int'(c))));
        end
        return CHAR_W'(ch);
    endfunction

    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < DIGITS + 1; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
        bcd_next  = {bcd_adj[BCD_W-2:0], bin_q[VALUE_W-1]};
        shift_out = bcd_adj[BCD_W-1];
    end

    // Anything carried into the guard digit, or shifted past it, means the
    // value does not fit in DIGITS decimal places.
    assign sat = ovf_q || (bcd_q[BCD_W-1 -: 4] != 4'd0);

    always_comb begin
        seen  = 1'b0;
        nib   = 4'd0;
        dchar = '{default: '0};
        for (int k = 0; k < DIGITS; k++) begin
            nib = sat ? 4'd9 : bcd_q[4*(DIGITS-1-k) +: 4];
            if (nib != 4'd0) begin
                seen = 1'b1;
            end
            if (ZERO_PAD == 0 && !seen && k != DIGITS - 1) begin
                dchar[k] = ASCII_SPACE;
            end else begin
                dchar[k] = ASCII_ZERO + CHAR_W'(nib);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            char_valid <= 1'b0;
            char_data  <= '0;
            char_col   <= '0;
            done       <= 1'b0;
            sel_q      <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            dig_q      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sel_q    <= line_sel;
                        bin_q    <= value;
                        bcd_q    <= '0;
                        ovf_q    <= 1'b0;
                        cnt_q    <= CNT_LOAD;
                        dig_q    <= '0;
                        char_col <= '0;
                        busy     <= 1'b1;
                        state    <= CONVERT;
                    end
                end

                CONVERT: begin
                    bcd_q <= bcd_next;
                    bin_q <= bin_q << 1;
                    ovf_q <= ovf_q | shift_out;
                    if (cnt_q == '0) begin
                        char_valid <= 1'b1;
                        char_data  <= label_char(sel_q, '0);
                        char_col   <= '0;
                        state      <= EMIT_LABEL;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                EMIT_LABEL: begin
                    if (char_ready) begin
                        char_col <= char_col + 1'b1;
                        if (char_col == LAST_LABEL_COL) begin
                            dig_q     <= '0;
                            char_data <= dchar[0];
                            state     <= EMIT_DIGITS;
                        end else begin
                            char_data <= label_char(sel_q, char_col + 1'b1);
                        end
                    end
                end

                EMIT_DIGITS: begin
                    if (char_ready) begin
                        if (char_col == LAST_COL) begin
                            char_valid <= 1'b0;
                            char_data  <= '0;
                            char_col   <= '0;
                            done       <= 1'b1;
                            state      <= DONE;
                        end else begin
                            char_col  <= char_col + 1'b1;
                            dig_q     <= dig_q + 1'b1;
                            char_data <= dchar[dig_q + 1'b1];
                        end
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_line_streamer.sv
// Bench for text_line_streamer: three parameterisations, a string-level model
// of the expected character stream, and directed literal checks.
module tb_text_line_streamer;

    logic       clk;
    logic       rst;
    logic       s   [3];
    logic       ls  [3];
    logic [9:0] val [3];
    logic       r   [3];
    logic       b   [3];
    logic       v   [3];
    logic [6:0] d   [3];
    logic [3:0] c   [3];
    logic       dn  [3];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int act = 0;
    int exp_q[$];
    int got_q[$];
    int t0 [3];
    int first_rel [3];
    bit seen_first [3];
    int done_rel [3];
    int done_cnt [3];
    bit hold_pending [3];

    text_line_streamer u_def (
        .clk(clk), .reset(rst), .start(s[0]), .line_sel(ls[0]), .value(val[0]),
        .busy(b[0]), .char_valid(v[0]), .char_ready(r[0]), .char_data(d[0]),
        .char_col(c[0]), .done(dn[0]));

    text_line_streamer #(.ZERO_PAD(1)) u_zp (
        .clk(clk), .reset(rst), .start(s[1]), .line_sel(ls[1]), .value(val[1]),
        .busy(b[1]), .char_valid(v[1]), .char_ready(r[1]), .char_data(d[1]),
        .char_col(c[1]), .done(dn[1]));

    text_line_streamer #(.DIGITS(3)) u_d3 (
        .clk(clk), .reset(rst), .start(s[2]), .line_sel(ls[2]), .value(val[2]),
        .busy(b[2]), .char_valid(v[2]), .char_ready(r[2]), .char_data(d[2]),
        .char_col(c[2]), .done(dn[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string name, int actual, int expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Expected stream from the line's text and the value's decimal rendering.
    task automatic build(int i, int line, int value);
        string lab;
        int digits, zp, vv, p, ch;
        digits = (i == 2) ? 3 : 4;
        zp     = (i == 1) ? 1 : 0;
        lab    = (line == 0) ? "score:" : (line == 1) ? "team:" : "";
        exp_q.delete();
        for (int col = 0; col < 6; col++) begin
            ch = (col < lab.len()) ? int'(lab[col]) : 0;
            exp_q.push_back(col * 256 + ch);
        end
        vv = value;
        if (vv > 10 ** digits - 1) vv = 10 ** digits - 1;
        for (int k = digits - 1; k >= 0; k--) begin
            p  = 10 ** k;
            ch = (zp == 0 && k > 0 && vv < p) ? 32 : 48 + (vv / p) % 10;
            exp_q.push_back((6 + digits - 1 - k) * 256 + ch);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            hold_pending[i] = !rst && v[i] && !r[i];
            if (!rst && v[i] && r[i] && i == act && exp_q.size() > 0) begin
                got_q.push_back(int'(d[i]));
                void'(exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (i != act || exp_q.size() == 0) begin
                chk("stray_valid", v[i], 0);
            end else if (v[i]) begin
                chk("char_data", d[i], exp_q[0] & 'hff);
                chk("char_col", c[i], exp_q[0] >> 8);
            end
            if (hold_pending[i] && !rst) chk("valid_held", v[i], 1);
            if (v[i] && !seen_first[i]) begin
                seen_first[i] = 1'b1;
                first_rel[i]  = cyc - t0[i];
            end
            if (dn[i]) begin
                done_cnt[i]++;
                done_rel[i] = cyc - t0[i];
                if (i == act) chk("done_with_chars_left", exp_q.size(), 0);
            end
        end
    end

    task automatic run_start(int i, int line, int value);
        @(posedge clk); #1;
        act = i;
        got_q.delete();
        build(i, line, value);
        seen_first[i] = 1'b0;
        ls[i]  = line[0];
        val[i] = value[9:0];
        s[i]   = 1'b1;
        t0[i]  = cyc;
        @(posedge clk); #1;
        s[i] = 1'b0;
        chk("busy_after_start", b[i], 1);
    endtask

    task automatic wait_done(int i, int budget);
        int n0;
        bit got;
        n0  = done_cnt[i];
        got = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk); #1;
            if (done_cnt[i] != n0) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_seen", got, 1);
    endtask

    task automatic wait_col(int i, int col);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (v[i] && int'(c[i]) == col) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_col", found, 1);
    endtask

    task automatic chk_str(string name, logic [79:0] e, int n);
        chk({name, "_len"}, got_q.size(), n);
        for (int k = 0; k < n && k < got_q.size(); k++) begin
            chk(name, got_q[k], int'((e >> (8 * (n - 1 - k))) & 80'h7f));
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s[i] = 1'b0; ls[i] = 1'b0; val[i] = '0; r[i] = 1'b1;
            done_cnt[i] = 0; seen_first[i] = 1'b0; t0[i] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", b[0], 0);
        chk("rst_valid", v[0], 0);
        chk("rst_done", dn[0], 0);
        chk("rst_data", d[0], 0);
        chk("rst_col", c[0], 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_start(0, 0, 42);
        wait_done(0, 100);
        chk("first_valid_cycle", first_rel[0], 11);
        chk("done_cycle", done_rel[0], 21);
        chk("busy_in_done", b[0], 1);
        @(posedge clk); #1;
        chk("busy_after_done", b[0], 0);
        chk("done_width", dn[0], 0);
        chk_str("score42", 80'h73636f72653a20203432, 10);

        run_start(0, 1, 0);
        wait_done(0, 100);
        chk_str("team0", 80'h7465616d3a0020202030, 10);

        run_start(1, 0, 7);
        wait_done(1, 100);
        chk_str("zeropad7", 80'h73636f72653a30303037, 10);

        run_start(0, 0, 1023);
        wait_col(0, 2);
        r[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("bp_data", d[0], 'h6f);
            chk("bp_col", c[0], 2);
            @(negedge clk);
        end
        r[0] = 1'b1;
        wait_done(0, 100);
        chk("bp_done_cycle", done_rel[0], 24);
        chk_str("bp1023", 80'h73636f72653a31303233, 10);

        run_start(2, 0, 1000);
        wait_done(2, 100);
        chk("d3_done_cycle", done_rel[2], 20);
        chk_str("sat1000", 80'h73636f72653a393939, 9);
        run_start(2, 0, 999);
        wait_done(2, 100);
        chk_str("d3_999", 80'h73636f72653a393939, 9);
        run_start(2, 0, 100);
        wait_done(2, 100);
        chk_str("d3_100", 80'h73636f72653a313030, 9);

        run_start(0, 0, 123);
        wait_col(0, 4);
        s[0] = 1'b1; val[0] = 10'd5; ls[0] = 1'b1;
        @(negedge clk);
        s[0] = 1'b0;
        wait_done(0, 100);
        n = done_cnt[0];
        chk_str("ignore_start", 80'h73636f72653a20313233, 10);
        repeat (30) @(posedge clk);
        #1;
        chk("single_done", done_cnt[0], n);
        chk("idle_after_ignore", b[0], 0);

        run_start(0, 0, 42);
        wait_col(0, 7);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_valid", v[0], 0);
        chk("rst_mid_busy", b[0], 0);
        chk("rst_mid_done", dn[0], 0);
        exp_q.delete();
        got_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        run_start(0, 0, 42);
        wait_done(0, 100);
        chk("post_rst_first_valid", first_rel[0], 11);
        chk("post_rst_done_cycle", done_rel[0], 21);
        chk_str("post_rst", 80'h73636f72653a20203432, 10);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
